// File: rtl/ccff_chain_loader.sv
// Loads a WORD_W-wide bitstream into a CHAIN_LEN-long configuration flip-flop chain, LSB first.
// Optional macro CCFF_READBACK_EN adds a recirculating VERIFY pass that compares ones counts.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BUF_W = $clog2(WORD_W + 1);

`ifdef CCFF_READBACK_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

  state_t            r_state, w_next_state;
  logic [WORD_W-1:0] r_buf;
  logic [BUF_W-1:0]  r_buf_cnt, w_take;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt, w_remain;
  logic              w_shift, w_idle, w_accept, w_cnt_full, w_restart;

  assign w_idle = (r_state == S_IDLE) || (r_state == S_DONE);

  always_comb begin
    w_shift = 1'b0;
    if (r_state == S_LOAD) w_shift = (r_buf_cnt != '0);
`ifdef CCFF_READBACK_EN
    if (r_state == S_VERIFY) w_shift = 1'b1;
`endif
  end

  assign w_bit_cnt_nxt = r_bit_cnt + CNT_W'(w_shift);
  assign w_cnt_full    = (w_bit_cnt_nxt == CNT_W'(CHAIN_LEN));
  // Bits still owed to the chain after this edge; a short final word is trimmed to this.
  assign w_remain      = CNT_W'(CHAIN_LEN) - w_bit_cnt_nxt;
  assign w_take        = (32'(w_remain) < WORD_W) ? BUF_W'(w_remain) : BUF_W'(WORD_W);
  assign w_accept      = word_valid && word_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge prog_clk) begin
    if (!pReset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next_state = S_LOAD;
`ifdef CCFF_READBACK_EN
      S_LOAD:   if (w_shift && w_cnt_full) w_next_state = S_VERIFY;
      S_VERIFY: if (w_cnt_full) w_next_state = S_DONE;
`else
      S_LOAD:   if (w_shift && w_cnt_full) w_next_state = S_DONE;
`endif
      default:  w_next_state = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    word_ready    = 1'b0;
    ccff_head     = 1'b0;
    ccff_shift_en = w_shift;
    case (r_state)
      S_LOAD: begin
        busy       = 1'b1;
        ccff_head  = w_shift & r_buf[0];
        // Buffer counts as empty while its last bit leaves, so words stream with no gap.
        word_ready = (r_buf_cnt <= BUF_W'(1)) && (w_bit_cnt_nxt < CNT_W'(CHAIN_LEN));
      end
`ifdef CCFF_READBACK_EN
      S_VERIFY: begin
        busy      = 1'b1;
        ccff_head = ccff_tail;
      end
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the word buffer is reset with the control state; it is one word, not a memory.
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      r_buf     <= '0;
      r_buf_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (w_idle && start) begin
      r_buf_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_buf     <= word_data;
        r_buf_cnt <= w_take;
      end else if (w_shift && (r_state == S_LOAD)) begin
        r_buf     <= r_buf >> 1;
        r_buf_cnt <= r_buf_cnt - BUF_W'(1);
      end
      if (w_shift) r_bit_cnt <= w_restart ? '0 : w_bit_cnt_nxt;
    end
  end

`ifdef CCFF_READBACK_EN
  logic [CNT_W-1:0] r_load_ones, r_tail_ones, w_tail_ones_nxt;
  logic             r_error;

  // The bit counter is reused to time the recirculation pass.
  assign w_restart       = (r_state == S_LOAD) && w_shift && w_cnt_full;
  assign w_tail_ones_nxt = r_tail_ones + CNT_W'(ccff_tail);
  assign error           = r_error;

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      r_load_ones <= '0;
      r_tail_ones <= '0;
      r_error     <= 1'b0;
    end else if (w_idle && start) begin
      r_load_ones <= '0;
      r_tail_ones <= '0;
      r_error     <= 1'b0;
    end else begin
      if ((r_state == S_LOAD) && w_shift) r_load_ones <= r_load_ones + CNT_W'(r_buf[0]);
      if (r_state == S_VERIFY) begin
        r_tail_ones <= w_tail_ones_nxt;
        if (w_cnt_full) r_error <= (w_tail_ones_nxt != r_load_ones);
      end
    end
  end
`else
  logic w_unused_tail;

  assign w_restart     = 1'b0;
  assign w_unused_tail = ccff_tail;
  assign error         = 1'b0;
`endif

endmodule
